// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, tracks outstanding requests,
// discards stale responses after a redirect and buffers words for decode.

module fetch_unit_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          imem_resp_valid,
    input logic [CW-1:0] pending,
    input logic [CW-1:0] drop,
    input logic [CW-1:0] count
);
    // Protocol and occupancy invariants, sampled on every active clock edge.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_resp_valid && (pending == '0) && (drop == '0)));
            assert (drop <= CW'(DEPTH));
            assert (count <= CW'(DEPTH));
            assert ((pending + drop) <= CW'(DEPTH));
        end
    end
endmodule

module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [WIDTH-1:0] imem_resp_data,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    pending_q, pending_d;
    logic [CW-1:0]    drop_q, drop_d;
    logic [WIDTH-1:0] q_pc_q   [DEPTH];
    logic [WIDTH-1:0] q_pc_d   [DEPTH];
    logic [WIDTH-1:0] q_data_q [DEPTH];
    logic [WIDTH-1:0] q_data_d [DEPTH];
    logic [PW-1:0]    q_head_q, q_head_d;
    logic [PW-1:0]    q_tail_q, q_tail_d;
    logic [WIDTH-1:0] af_pc_q  [DEPTH];
    logic [WIDTH-1:0] af_pc_d  [DEPTH];
    logic [PW-1:0]    af_wr_q, af_wr_d;
    logic [PW-1:0]    af_rd_q, af_rd_d;

    logic accept_s;
    logic push_s;
    logic pop_s;
    logic stale_s;

    // Issue only when both the queue and the stale-tracking budget have room.
    assign imem_req_valid = !rst && !redirect
                          && (({1'b0, count_q} + {1'b0, pending_q}) < DEPTH_S)
                          && (({1'b0, pending_q} + {1'b0, drop_q}) < DEPTH_S);
    assign imem_req_addr  = fetch_pc_q;
    assign accept_s       = imem_req_valid && imem_req_ready;
    assign stale_s        = imem_resp_valid && (drop_q != '0);
    assign push_s         = imem_resp_valid && !redirect && (drop_q == '0);
    assign pop_s          = instr_valid && instr_ready && !redirect;

    assign instr_valid    = (count_q != '0);
    assign instr          = q_data_q[q_head_q];
    assign instr_pc       = q_pc_q[q_head_q];

    // Next-state computation for fetch PC, counters, instruction queue and address FIFO.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        pending_d  = pending_q;
        drop_d     = drop_q;
        q_pc_d     = q_pc_q;
        q_data_d   = q_data_q;
        q_head_d   = q_head_q;
        q_tail_d   = q_tail_q;
        af_pc_d    = af_pc_q;
        af_wr_d    = af_wr_q;
        af_rd_d    = af_rd_q;

        // Every response, live or stale, retires the oldest tracked address.
        if (accept_s) begin
            af_pc_d[af_wr_q] = fetch_pc_q;
            af_wr_d          = ptr_inc(af_wr_q);
        end else begin
            af_wr_d = af_wr_q;
        end
        if (imem_resp_valid) begin
            af_rd_d = ptr_inc(af_rd_q);
        end else begin
            af_rd_d = af_rd_q;
        end

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            pending_d  = '0;
            drop_d     = drop_q + pending_q - CW'(imem_resp_valid);
            q_head_d   = '0;
            q_tail_d   = '0;
        end else begin
            fetch_pc_d = accept_s ? (fetch_pc_q + WIDTH'(4)) : fetch_pc_q;
            pending_d  = pending_q + CW'(accept_s) - CW'(push_s);
            drop_d     = drop_q - CW'(stale_s);
            count_d    = count_q + CW'(push_s) - CW'(pop_s);
            q_head_d   = pop_s ? ptr_inc(q_head_q) : q_head_q;
            q_tail_d   = push_s ? ptr_inc(q_tail_q) : q_tail_q;
            if (push_s) begin
                q_pc_d[q_tail_q]   = af_pc_q[af_rd_q];
                q_data_d[q_tail_q] = imem_resp_data;
            end else begin
                q_pc_d   = q_pc_q;
                q_data_d = q_data_q;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            pending_q  <= '0;
            drop_q     <= '0;
            q_pc_q     <= '{default: '0};
            q_data_q   <= '{default: '0};
            q_head_q   <= '0;
            q_tail_q   <= '0;
            af_pc_q    <= '{default: '0};
            af_wr_q    <= '0;
            af_rd_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            q_pc_q     <= q_pc_d;
            q_data_q   <= q_data_d;
            q_head_q   <= q_head_d;
            q_tail_q   <= q_tail_d;
            af_pc_q    <= af_pc_d;
            af_wr_q    <= af_wr_d;
            af_rd_q    <= af_rd_d;
        end
    end

    fetch_unit_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk             (clk),
        .rst             (rst),
        .imem_resp_valid (imem_resp_valid),
        .pending         (pending_q),
        .drop            (drop_q),
        .count           (count_q)
    );
endmodule
